// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-count debounce FSM,
// press/release/long-press pulses and a wrapping press counter.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       long_press,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_MAX = 16'(LONG_CYCLES);

    logic        s1_q, s2_q;
    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] hold_q, hold_d;
    logic        long_hit_d;
    logic        btn_level_q, btn_press_q, btn_release_q, long_press_q;
    logic [7:0]  press_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // Saturating hold count; long_press fires only on the step that reaches the limit.
    always_comb begin
        hold_d     = hold_q;
        long_hit_d = 1'b0;
        if (hold_q != HOLD_MAX) begin
            hold_d     = hold_q + 16'd1;
            long_hit_d = (hold_q == (HOLD_MAX - 16'd1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LOW;
            cnt_q         <= 16'd0;
            hold_q        <= 16'd0;
            btn_level_q   <= 1'b0;
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
            long_press_q  <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
            long_press_q  <= 1'b0;
            case (state_q)
                LOW: begin
                    if (s2_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= 16'd0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2_q) begin
                        state_q <= LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= HIGH;
                        btn_level_q   <= 1'b1;
                        btn_press_q   <= 1'b1;
                        press_count_q <= press_count_q + 8'd1;
                        hold_q        <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HIGH: begin
                    hold_q       <= hold_d;
                    long_press_q <= long_hit_d;
                    if (!s2_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= 16'd0;
                    end
                end
                WAIT_LOW: begin
                    // The accepting release step does not advance hold, so long_press never lands with btn_release.
                    if (s2_q) begin
                        state_q      <= HIGH;
                        hold_q       <= hold_d;
                        long_press_q <= long_hit_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= LOW;
                        btn_level_q   <= 1'b0;
                        btn_release_q <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_q + 16'd1;
                        hold_q       <= hold_d;
                        long_press_q <= long_hit_d;
                    end
                end
                default: state_q <= LOW;
            endcase
        end
    end

    assign btn_level   = btn_level_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;
    assign long_press  = long_press_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20;
// edge k below is the k-th rising edge after btn_in changes.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       btn_level, btn_press, btn_release, long_press;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;
    int expCount = 0;

    btn_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .long_press  (long_press),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        expCount = 0;
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        btn_in = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if ({btn_level, btn_press, btn_release, long_press, press_count} !== 12'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %b/%b/%b/%b/%0d required all 0",
                     btn_level, btn_press, btn_release, long_press, press_count);
        end
        btn_in = 1'b0;
        rst    = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release, long_press} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_idle edge %0d: got %b%b%b%b required 0000",
                         k, btn_level, btn_press, btn_release, long_press);
            end
        end
    endtask

    task automatic test_clean_press;
        btn_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_press !== (k == 7) || btn_level !== (k >= 7)) begin
                failures++;
                $display("[TB] FAIL clean_press edge %0d: got press=%b level=%b required press=%b level=%b",
                         k, btn_press, btn_level, (k == 7), (k >= 7));
            end
        end
        expCount++;
        checks++;
        if (press_count !== 8'(expCount)) begin
            failures++;
            $display("[TB] FAIL clean_press_count: got %0d required %0d", press_count, expCount);
        end
        btn_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_release !== (k == 7) || btn_level !== (k < 7) || btn_press !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clean_release edge %0d: got rel=%b level=%b press=%b required rel=%b level=%b press=0",
                         k, btn_release, btn_level, btn_press, (k == 7), (k < 7));
            end
        end
    endtask

    task automatic test_glitch;
        for (int k = 1; k <= 14; k++) begin
            btn_in = (k <= 4);
            tick();
            checks++;
            if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch edge %0d: got level=%b press=%b rel=%b required 0/0/0",
                         k, btn_level, btn_press, btn_release);
            end
        end
        checks++;
        if (press_count !== 8'(expCount)) begin
            failures++;
            $display("[TB] FAIL glitch_count: got %0d required %0d", press_count, expCount);
        end
    endtask

    task automatic test_bouncy_release;
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        expCount++;
        // Low on edges 1-2, high on edge 3, low from edge 4: release lands on edge 10.
        for (int k = 1; k <= 14; k++) begin
            btn_in = (k == 3);
            tick();
            checks++;
            if (btn_release !== (k == 10) || btn_level !== (k < 10) || btn_press !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bouncy_release edge %0d: got rel=%b level=%b press=%b required rel=%b level=%b press=0",
                         k, btn_release, btn_level, btn_press, (k == 10), (k < 10));
            end
        end
    endtask

    task automatic test_long_press;
        btn_in = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            tick();
            checks++;
            if (long_press !== (k == 27) || btn_press !== (k == 7)) begin
                failures++;
                $display("[TB] FAIL long_press edge %0d: got long=%b press=%b required long=%b press=%b",
                         k, long_press, btn_press, (k == 27), (k == 7));
            end
        end
        expCount++;
        for (int k = 1; k <= 35; k++) begin
            btn_in = !(k == 1 || k == 2);
            tick();
            checks++;
            if (long_press !== 1'b0 || btn_level !== 1'b1 || btn_release !== 1'b0) begin
                failures++;
                $display("[TB] FAIL long_bounce edge %0d: got long=%b level=%b rel=%b required 0/1/0",
                         k, long_press, btn_level, btn_release);
            end
        end
        btn_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_release !== (k == 7) || long_press !== 1'b0) begin
                failures++;
                $display("[TB] FAIL long_release edge %0d: got rel=%b long=%b required rel=%b long=0",
                         k, btn_release, long_press, (k == 7));
            end
        end
        checks++;
        if (press_count !== 8'(expCount)) begin
            failures++;
            $display("[TB] FAIL long_count: got %0d required %0d", press_count, expCount);
        end
    endtask

    task automatic test_wrap;
        int pressSeen;
        pressSeen = 0;
        doReset();
        for (int i = 1; i <= 256; i++) begin
            for (int k = 0; k < 20; k++) begin
                btn_in = (k < 10);
                tick();
                if (btn_press === 1'b1) pressSeen++;
            end
            if (i == 255) begin
                checks++;
                if (press_count !== 8'd255) begin
                    failures++;
                    $display("[TB] FAIL wrap_255: got %0d required 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d required 0", press_count);
        end
        checks++;
        if (pressSeen != 256) begin
            failures++;
            $display("[TB] FAIL wrap_pulses: got %0d required 256", pressSeen);
        end
    endtask

    task automatic test_reset_mid_press;
        doReset();
        btn_in = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        btn_in = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        btn_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, long_press, press_count} !== 12'd0) begin
            failures++;
            $display("[TB] FAIL mid_wait_reset: got %b/%b/%b/%b/%0d required all 0",
                     btn_level, btn_press, btn_release, long_press, press_count);
        end
        btn_in = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (btn_press !== 1'b0 || btn_release !== 1'b0 || btn_level !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_wait_after edge %0d: got press=%b rel=%b level=%b required 0/0/0",
                         k, btn_press, btn_release, btn_level);
            end
        end
        btn_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_press !== (k == 7) || press_count !== ((k >= 7) ? 8'd1 : 8'd0)) begin
                failures++;
                $display("[TB] FAIL fresh_press edge %0d: got press=%b count=%0d required press=%b count=%0d",
                         k, btn_press, press_count, (k == 7), (k >= 7) ? 1 : 0);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (btn_level !== 1'b0 || press_count !== 8'd0) begin
            failures++;
            $display("[TB] FAIL mid_high_reset: got level=%b count=%0d required 0/0", btn_level, press_count);
        end
        btn_in = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (btn_press !== 1'b0 || btn_release !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_high_after edge %0d: got press=%b rel=%b required 0/0",
                         k, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_reset_btn_high;
        btn_in = 1'b1;
        rst    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (btn_press !== (k == 7) || btn_level !== (k >= 7)) begin
                failures++;
                $display("[TB] FAIL reset_btn_high edge %0d: got press=%b level=%b required press=%b level=%b",
                         k, btn_press, btn_level, (k == 7), (k >= 7));
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL reset_btn_high_count: got %0d required 1", press_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bouncy_release();
        test_long_press();
        test_wrap();
        test_reset_mid_press();
        test_reset_btn_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 SHALL have parameter LONG_CYCLES, default 1000: number of cycles in the accepted-high state before long_press fires (legal range >DEBOUNCE_CYCLES, ≤65535).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port btn_in, input, 1 bit: raw asynchronous button level, bouncy, active-high.
REQ-006 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 SHALL have port btn_press, output, 1 bit: one-cycle pulse on accepted 0->1 change.
REQ-008 SHALL have port btn_release, output, 1 bit: one-cycle pulse on accepted 1->0 change.
REQ-009 SHALL have port long_press, output, 1 bit: one-cycle pulse, at most once per press, when the accepted-high state lasts LONG_CYCLES.
REQ-010 SHALL have port press_count, output, 8 bits: count of accepted presses, modulo 256.

Function
REQ-011 SHALL pass btn_in through a two-flop synchronizer (s1, s2); only s2 feeds the FSM.
REQ-012 SHALL implement FSM states LOW, WAIT_HIGH, HIGH, WAIT_LOW, with a 16-bit stability counter cnt.
REQ-013 LOW: s2=1 -> WAIT_HIGH with cnt=0; else stay.
REQ-014 WAIT_HIGH: s2=0 -> LOW with no output change; s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; else cnt+1.
REQ-015 HIGH: s2=0 -> WAIT_LOW with cnt=0; else stay.
REQ-016 WAIT_LOW: s2=1 -> HIGH with no output change; s2=0 and cnt=DEBOUNCE_CYCLES-1 -> LOW; else cnt+1.
REQ-017 SHALL register all outputs; btn_level SHALL be 1 exactly while in HIGH or WAIT_LOW.
REQ-018 For btn_in rising and held stable, btn_level and btn_press SHALL assert at the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples btn_in=1 as edge 1; release latency is symmetric.
REQ-019 btn_press SHALL be high for exactly the one cycle following the WAIT_HIGH->HIGH transition; btn_release likewise for WAIT_LOW->LOW.
REQ-020 press_count SHALL increment by 1 in the same cycle btn_press asserts, wrapping 255->0.
REQ-021 SHALL keep a hold counter, cleared on entry to HIGH from WAIT_HIGH and incremented in HIGH/WAIT_LOW, saturating at LONG_CYCLES; long_press SHALL pulse once when it reaches LONG_CYCLES.
REQ-022 A WAIT_LOW bounce returning to HIGH SHALL NOT clear the hold counter or re-arm long_press.
REQ-023 Pulses SHALL never assert in the same cycle as each other, except long_press may never coincide with btn_press.

Reset
REQ-024 rst low SHALL asynchronously force state LOW, s1=s2=0, cnt=0, hold counter=0, btn_level=0, btn_press=0, btn_release=0, long_press=0, press_count=0.
REQ-025 Reset asserted mid-WAIT_HIGH or mid-HIGH SHALL produce no btn_press/btn_release pulse on or after deassertion until a fresh qualifying press.
REQ-026 After rst deasserts with btn_in already high, the block SHALL treat it as a new press (normal REQ-018 latency).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-027 Clean press: btn_in 0->1 held -> btn_level=1 and btn_press single pulse at edge 7; press_count=1.
REQ-028 Glitch: btn_in high for 4 cycles then low -> btn_level stays 0, no pulses, press_count unchanged.
REQ-029 Bouncy release: in HIGH, btn_in low 2 cycles, high 1, then low held -> one btn_release only, 7 edges after final fall.
REQ-030 Long press: hold 30 cycles past acceptance -> exactly one long_press, 20 cycles after btn_press; none after a 2-cycle bounce.
REQ-031 Wrap: 256 clean presses -> press_count returns to 0, 256 btn_press pulses.
REQ-032 Reset mid-press: rst low during WAIT_HIGH -> all outputs 0 immediately, no pulse after release of rst until a new press completes.
